// File: rtl/musa_pkg.sv
// Shared definitions for the sequencer: branch codes, default address width
// and the run/halt state encoding.
package musa_pkg;

    localparam int ADDR_W_DEFAULT = 16;

    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_JR   = 3'b001;
    localparam logic [2:0] BR_CALL = 3'b010;
    localparam logic [2:0] BR_HALT = 3'b011;
    localparam logic [2:0] BR_JPC  = 3'b100;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } seq_state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control-unit to sequencer bundle: commit/branch controls in, fetch address
// and sequencer status out.
interface pc_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int LVL_W  = 4
);
    logic              write_pc;
    logic [2:0]        branch;
    logic              push;
    logic              pop;
    logic              add_pc;
    logic              brfl_control;
    logic              flag;
    logic [ADDR_W-1:0] reg_target;
    logic [ADDR_W-1:0] imm_target;
    logic [ADDR_W-1:0] rel_offset;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              stack_overflow;
    logic              stack_underflow;
    logic [LVL_W-1:0]  stack_level;

    modport master (
        output write_pc, branch, push, pop, add_pc, brfl_control, flag,
               reg_target, imm_target, rel_offset,
        input  pc, halted, stack_overflow, stack_underflow, stack_level
    );

    modport slave (
        input  write_pc, branch, push, pop, add_pc, brfl_control, flag,
               reg_target, imm_target, rel_offset,
        output pc, halted, stack_overflow, stack_underflow, stack_level
    );
endinterface

// File: rtl/pc_sequencer_return_stack.sv
// Return-address LIFO. Reports full/empty only; the owner decides what an
// illegal push or pop means. A push with pop is treated as a push.
module return_stack #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [DATA_W-1:0]          wdata_i,
    output logic [DATA_W-1:0]          top_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [LVL_W-1:0]  level_q, level_d;
    logic [PTR_W-1:0]  wr_idx, top_idx;
    logic              do_push, do_pop;

    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);
    assign level_o = level_q;

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !push_i && !empty_o;

    assign wr_idx  = level_q[PTR_W-1:0];
    assign top_idx = PTR_W'(level_q - 1'b1);
    assign top_o   = mem_q[top_idx];

    always_comb begin
        level_d = level_q;
        if (do_push) begin
            level_d = level_q + 1'b1;
        end else if (do_pop) begin
            level_d = level_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    // Storage carries no reset; only the level decides which entries are live.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_idx] <= wdata_i;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks the next fetch address on each commit,
// drives the return stack for call/ret and latches halt/stack faults.
module pc_sequencer
    import musa_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEFAULT,
    parameter int STACK_DEPTH = 8,
    parameter int RESET_PC    = 0
) (
    input  logic           clk,
    input  logic           rst,
    pc_sequencer_if.slave  bus
);
    localparam int LVL_W = $clog2(STACK_DEPTH) + 1;

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;

    logic              stk_push, stk_pop;
    logic [ADDR_W-1:0] stk_top;
    logic [LVL_W-1:0]  stk_level;
    logic              stk_full, stk_empty;

    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] base);
        return base + ADDR_W'(1);
    endfunction

    // Offset is two's complement; the modulo-2^ADDR_W sum gives the wrap.
    function automatic logic [ADDR_W-1:0] pc_rel(input logic [ADDR_W-1:0] base,
                                                input logic signed [ADDR_W-1:0] off);
        return base + $unsigned(off);
    endfunction

    return_stack #(
        .DATA_W (ADDR_W),
        .DEPTH  (STACK_DEPTH)
    ) u_stack (
        .clk     (clk),
        .rst     (rst),
        .push_i  (stk_push),
        .pop_i   (stk_pop),
        .wdata_i (pc_q),
        .top_o   (stk_top),
        .level_o (stk_level),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;

        if (state_q == RUN && bus.write_pc) begin
            if (bus.push && stk_full) begin
                // Overflowing call is suppressed entirely, including its jump.
                ovf_d   = 1'b1;
                state_d = HALTED;
            end else begin
                stk_push = bus.push;
                if (bus.pop && !bus.push) begin
                    if (stk_empty) begin
                        unf_d   = 1'b1;
                        state_d = HALTED;
                    end else begin
                        pc_d    = bus.add_pc ? pc_inc(stk_top) : stk_top;
                        stk_pop = 1'b1;
                    end
                end else if (bus.brfl_control) begin
                    pc_d = bus.flag ? bus.imm_target : pc_inc(pc_q);
                end else begin
                    case (bus.branch)
                        BR_HALT: state_d = HALTED;
                        BR_JR:   pc_d    = bus.reg_target;
                        BR_CALL: pc_d    = bus.imm_target;
                        BR_JPC:  pc_d    = pc_rel(pc_q, bus.rel_offset);
                        default: pc_d    = pc_inc(pc_q);
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= ADDR_W'(RESET_PC);
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc              = pc_q;
    assign bus.halted          = (state_q == HALTED);
    assign bus.stack_overflow  = ovf_q;
    assign bus.stack_underflow = unf_q;
    assign bus.stack_level     = stk_level;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios then random commits,
// each checked against a queue-based reference model.
module tb_pc_sequencer;
    localparam int ADDR_W   = 16;
    localparam int DEPTH    = 8;
    localparam int LVL_W    = 4;
    localparam int RESET_PC = 0;

    typedef struct {
        logic        rst;
        logic        wpc;
        logic [2:0]  br;
        logic        push;
        logic        pop;
        logic        addpc;
        logic        brfl;
        logic        flag;
        logic [15:0] rt;
        logic [15:0] it;
        logic [15:0] ro;
    } stim_t;

    typedef struct {
        logic [15:0] pc;
        logic        halted;
        logic        ovf;
        logic        unf;
        logic [3:0]  level;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(ADDR_W), .LVL_W(LVL_W)) bus ();

    pc_sequencer #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .RESET_PC    (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model state
    int   m_pc  = RESET_PC;
    bit   m_halt = 0;
    bit   m_ovf = 0;
    bit   m_unf = 0;
    int   m_stack[$];

    task automatic model(input stim_t s);
        exp_t e;
        int   old_pc;
        if (s.rst) begin
            m_pc = RESET_PC; m_halt = 0; m_ovf = 0; m_unf = 0;
            m_stack.delete();
        end else if (!m_halt && s.wpc) begin
            old_pc = m_pc;
            if (s.push && m_stack.size() == DEPTH) begin
                m_ovf = 1; m_halt = 1;
            end else begin
                if (s.push) m_stack.push_back(old_pc);
                if (s.pop && !s.push) begin
                    if (m_stack.size() == 0) begin
                        m_unf = 1; m_halt = 1;
                    end else begin
                        m_pc = (m_stack.pop_back() + (s.addpc ? 1 : 0)) % 65536;
                    end
                end else if (s.brfl) begin
                    m_pc = s.flag ? int'(s.it) : (old_pc + 1) % 65536;
                end else if (s.br == 3'd3) begin
                    m_halt = 1;
                end else if (s.br == 3'd1) begin
                    m_pc = int'(s.rt);
                end else if (s.br == 3'd2) begin
                    m_pc = int'(s.it);
                end else if (s.br == 3'd4) begin
                    m_pc = (old_pc + int'(s.ro)) % 65536;
                end else begin
                    m_pc = (old_pc + 1) % 65536;
                end
            end
        end
        e.pc     = 16'(m_pc);
        e.halted = m_halt;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        e.level  = 4'(m_stack.size());
        exp_q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        @(negedge clk);
        rst              = s.rst;
        bus.write_pc     = s.wpc;
        bus.branch       = s.br;
        bus.push         = s.push;
        bus.pop          = s.pop;
        bus.add_pc       = s.addpc;
        bus.brfl_control = s.brfl;
        bus.flag         = s.flag;
        bus.reg_target   = s.rt;
        bus.imm_target   = s.it;
        bus.rel_offset   = s.ro;
        model(s);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s.rst = 0; s.wpc = 0; s.br = 3'd0; s.push = 0; s.pop = 0; s.addpc = 0;
        s.brfl = 0; s.flag = 0; s.rt = '0; s.it = '0; s.ro = '0;
        return s;
    endfunction

    task automatic do_rst();
        stim_t s = idle();
        s.rst = 1;
        drive(s);
    endtask

    task automatic commit(input logic [2:0] br, input logic push, input logic pop,
                          input logic addpc, input logic brfl, input logic flag,
                          input logic [15:0] rt, input logic [15:0] it,
                          input logic [15:0] ro);
        stim_t s = idle();
        s.wpc = 1; s.br = br; s.push = push; s.pop = pop; s.addpc = addpc;
        s.brfl = brfl; s.flag = flag; s.rt = rt; s.it = it; s.ro = ro;
        drive(s);
    endtask

    task automatic hold();
        drive(idle());
    endtask

    // Monitor: one registered result per clock edge that had stimulus behind it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (bus.pc !== e.pc || bus.halted !== e.halted ||
                    bus.stack_overflow !== e.ovf || bus.stack_underflow !== e.unf ||
                    bus.stack_level !== e.level) begin
                    fails++;
                    $display("FAIL state t=%0t: got pc=%h halted=%b ovf=%b unf=%b lvl=%0d, expected pc=%h halted=%b ovf=%b unf=%b lvl=%0d",
                             $time, bus.pc, bus.halted, bus.stack_overflow,
                             bus.stack_underflow, bus.stack_level,
                             e.pc, e.halted, e.ovf, e.unf, e.level);
                end
            end
        end
    end

    initial begin
        stim_t s;
        int    wait_cyc;
        bus.write_pc = 0; bus.branch = '0; bus.push = 0; bus.pop = 0;
        bus.add_pc = 0; bus.brfl_control = 0; bus.flag = 0;
        bus.reg_target = '0; bus.imm_target = '0; bus.rel_offset = '0;

        // Sequential counting with holds in between
        do_rst();
        for (int i = 0; i < 4; i++) begin
            commit(3'd0, 0, 0, 0, 0, 0, '0, '0, '0);
            hold();
        end

        // Call and return with add_pc
        commit(3'd1, 0, 0, 0, 0, 0, 16'h0010, '0, '0);
        commit(3'd2, 1, 0, 0, 0, 0, '0, 16'h0200, '0);
        commit(3'd0, 0, 1, 1, 0, 0, '0, '0, '0);

        // Conditional branch and negative relative jump
        commit(3'd0, 0, 0, 0, 1, 1, '0, 16'h0040, '0);
        commit(3'd0, 0, 0, 0, 1, 0, '0, 16'h0040, '0);
        commit(3'd4, 0, 0, 0, 0, 0, '0, '0, 16'hFFFE);

        // Wrap, register jump, halt freeze, reset out of halt
        commit(3'd1, 0, 0, 0, 0, 0, 16'hFFFF, '0, '0);
        commit(3'd0, 0, 0, 0, 0, 0, '0, '0, '0);
        commit(3'd1, 0, 0, 0, 0, 0, 16'h1234, '0, '0);
        commit(3'd3, 0, 0, 0, 0, 0, '0, '0, '0);
        commit(3'd0, 0, 0, 0, 0, 0, '0, '0, '0);
        commit(3'd1, 1, 0, 0, 0, 0, 16'h5555, '0, '0);
        do_rst();

        // Nine nested calls overflow the eight-entry stack
        for (int i = 0; i < 9; i++)
            commit(3'd2, 1, 0, 0, 0, 0, '0, 16'(16'h0100 + i * 16), '0);
        commit(3'd0, 0, 0, 0, 0, 0, '0, '0, '0);

        // Pop on empty
        do_rst();
        commit(3'd0, 0, 1, 0, 0, 0, '0, '0, '0);
        commit(3'd0, 0, 0, 0, 0, 0, '0, '0, '0);

        // Push with pop executes the push only; reset beats a commit
        do_rst();
        commit(3'd2, 1, 0, 0, 0, 0, '0, 16'h0300, '0);
        commit(3'd2, 1, 0, 0, 0, 0, '0, 16'h0400, '0);
        commit(3'd0, 1, 1, 1, 0, 0, '0, '0, '0);
        s = idle();
        s.rst = 1; s.wpc = 1; s.br = 3'd1; s.rt = 16'hBEEF; s.push = 1;
        drive(s);

        // Randomized commits with occasional reset
        for (int n = 0; n < 2000; n++) begin
            s.rst   = ($urandom_range(0, 59) == 0);
            s.wpc   = ($urandom_range(0, 3) != 0);
            s.br    = 3'($urandom_range(0, 7));
            s.push  = ($urandom_range(0, 4) == 0);
            s.pop   = ($urandom_range(0, 4) == 0);
            s.addpc = 1'($urandom);
            s.brfl  = ($urandom_range(0, 6) == 0);
            s.flag  = 1'($urandom);
            s.rt    = 16'($urandom);
            s.it    = 16'($urandom);
            s.ro    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            if (s.br == 3'd3 && $urandom_range(0, 2) != 0) s.br = 3'd0;
            drive(s);
        end

        s = idle();
        drive(s);
        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
